// File: rtl/flash_op_arbiter.sv
// flash_op_arbiter: shares the single Flash_ctrl user port between two requesters.
// Arbitrates operation requests (round-robin or fixed priority), forwards the granted
// request, steers its write stream downstream and returns read data to the owner.
// Optional watchdog: define FLASH_ARB_TIMEOUT_EN (adds parameter P_TIMEOUT_CYC).
module flash_op_arbiter #(
    parameter int unsigned P_DATA_WIDTH  = 8,
    parameter int unsigned P_ARB_MODE    = 0
`ifdef FLASH_ARB_TIMEOUT_EN
    ,
    parameter logic [31:0] P_TIMEOUT_CYC = 32'd25000000
`endif
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    // requester 0
    input  logic [1:0]              i_req0_operation_type,
    input  logic [23:0]             i_req0_operation_addr,
    input  logic [8:0]              i_req0_operation_byte_num,
    input  logic                    i_req0_operation_valid,
    output logic                    o_req0_operation_ready,
    input  logic [P_DATA_WIDTH-1:0] i_req0_write_data,
    input  logic                    i_req0_write_sop,
    input  logic                    i_req0_write_eop,
    input  logic                    i_req0_write_valid,
    output logic [P_DATA_WIDTH-1:0] o_req0_read_data,
    output logic                    o_req0_read_sop,
    output logic                    o_req0_read_eop,
    output logic                    o_req0_read_valid,
    // requester 1
    input  logic [1:0]              i_req1_operation_type,
    input  logic [23:0]             i_req1_operation_addr,
    input  logic [8:0]              i_req1_operation_byte_num,
    input  logic                    i_req1_operation_valid,
    output logic                    o_req1_operation_ready,
    input  logic [P_DATA_WIDTH-1:0] i_req1_write_data,
    input  logic                    i_req1_write_sop,
    input  logic                    i_req1_write_eop,
    input  logic                    i_req1_write_valid,
    output logic [P_DATA_WIDTH-1:0] o_req1_read_data,
    output logic                    o_req1_read_sop,
    output logic                    o_req1_read_eop,
    output logic                    o_req1_read_valid,
    // Flash_ctrl side
    output logic [1:0]              o_operation_type,
    output logic [23:0]             o_operation_addr,
    output logic [8:0]              o_operation_byte_num,
    output logic                    o_operation_valid,
    input  logic                    i_operation_ready,
    output logic [P_DATA_WIDTH-1:0] o_write_data,
    output logic                    o_write_sop,
    output logic                    o_write_eop,
    output logic                    o_write_valid,
    input  logic [P_DATA_WIDTH-1:0] i_read_data,
    input  logic                    i_read_sop,
    input  logic                    i_read_eop,
    input  logic                    i_read_valid,
    // status
    output logic [1:0]              o_grant,
    output logic                    o_op_err,
    output logic                    o_timeout
);

    typedef enum logic [1:0] {StIdle, StIssue, StRun} state_e;

    state_e      state_q, state_d;
    logic        last_q, last_d;          // 1: req1 was served last
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  type_q, type_d;
    logic [23:0] addr_q, addr_d;
    logic [8:0]  num_q, num_d;
    logic        op_valid_q, op_valid_d;
    logic        op_err_q, op_err_d;
    logic        run_first_q, run_first_d; // first RUN cycle: ready still reflects the accept
    logic        eop_seen_q, eop_seen_d;
    logic        win0, win1;
    logic [1:0]  sel_type;
    logic        read_eop, done;
`ifdef FLASH_ARB_TIMEOUT_EN
    logic [31:0] cnt_q, cnt_d;
    logic        timeout_q, timeout_d;
`endif

    // Arbitration winner among the currently valid requests
    always_comb begin
        win0 = 1'b0;
        win1 = 1'b0;
        if (i_req0_operation_valid && i_req1_operation_valid) begin
            if (P_ARB_MODE != 0 || last_q) win0 = 1'b1;
            else                           win1 = 1'b1;
        end else begin
            win0 = i_req0_operation_valid;
            win1 = i_req1_operation_valid;
        end
    end

    assign o_req0_operation_ready = (state_q == StIdle) && win0;
    assign o_req1_operation_ready = (state_q == StIdle) && win1;
    assign sel_type = win1 ? i_req1_operation_type : i_req0_operation_type;
    assign read_eop = i_read_eop && i_read_valid;
    // Reads finish only once the last beat has been returned (possibly this very cycle)
    assign done     = i_operation_ready && ((type_q != 2'd1) || eop_seen_q || read_eop);

    // Next-state logic for the operation FSM and its latched request
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        grant_d     = grant_q;
        type_d      = type_q;
        addr_d      = addr_q;
        num_d       = num_q;
        op_valid_d  = op_valid_q;
        op_err_d    = 1'b0;
        run_first_d = run_first_q;
        eop_seen_d  = eop_seen_q | read_eop;
`ifdef FLASH_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        timeout_d   = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (win0 || win1) begin
                    last_d = win1;
                    if (sel_type == 2'd3) begin
                        op_err_d = 1'b1;
                        grant_d  = 2'b00;
                    end else begin
                        type_d     = sel_type;
                        addr_d     = win1 ? i_req1_operation_addr : i_req0_operation_addr;
                        num_d      = win1 ? i_req1_operation_byte_num
                                          : i_req0_operation_byte_num;
                        grant_d    = {win1, win0};
                        op_valid_d = 1'b1;
                        eop_seen_d = 1'b0;
                        state_d    = StIssue;
`ifdef FLASH_ARB_TIMEOUT_EN
                        cnt_d      = '0;
`endif
                    end
                end
            end
            StIssue: begin
                if (i_operation_ready) begin
                    op_valid_d  = 1'b0;
                    run_first_d = 1'b1;
                    state_d     = StRun;
                end
            end
            StRun: begin
                run_first_d = 1'b0;
                if (!run_first_q && done) begin
                    grant_d = 2'b00;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
`ifdef FLASH_ARB_TIMEOUT_EN
        // Watchdog only fires if the operation is not completing this cycle
        if (state_q != StIdle && state_d != StIdle) begin
            if (cnt_q == P_TIMEOUT_CYC - 32'd1) begin
                timeout_d   = 1'b1;
                op_valid_d  = 1'b0;
                grant_d     = 2'b00;
                run_first_d = 1'b0;
                state_d     = StIdle;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end
`endif
    end

    // State and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            last_q      <= 1'b1;
            grant_q     <= 2'b00;
            type_q      <= 2'd0;
            addr_q      <= 24'd0;
            num_q       <= 9'd0;
            op_valid_q  <= 1'b0;
            op_err_q    <= 1'b0;
            run_first_q <= 1'b0;
            eop_seen_q  <= 1'b0;
`ifdef FLASH_ARB_TIMEOUT_EN
            cnt_q       <= 32'd0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            type_q      <= type_d;
            addr_q      <= addr_d;
            num_q       <= num_d;
            op_valid_q  <= op_valid_d;
            op_err_q    <= op_err_d;
            run_first_q <= run_first_d;
            eop_seen_q  <= eop_seen_d;
`ifdef FLASH_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    // Write steering: only the granted requester reaches the controller
    always_comb begin
        o_write_data  = '0;
        o_write_sop   = 1'b0;
        o_write_eop   = 1'b0;
        o_write_valid = 1'b0;
        unique case (grant_q)
            2'b01: begin
                o_write_data  = i_req0_write_data;
                o_write_sop   = i_req0_write_sop;
                o_write_eop   = i_req0_write_eop;
                o_write_valid = i_req0_write_valid;
            end
            2'b10: begin
                o_write_data  = i_req1_write_data;
                o_write_sop   = i_req1_write_sop;
                o_write_eop   = i_req1_write_eop;
                o_write_valid = i_req1_write_valid;
            end
            default: ;
        endcase
    end

    assign o_req0_read_data  = i_read_data;
    assign o_req0_read_sop   = i_read_sop & grant_q[0];
    assign o_req0_read_eop   = i_read_eop & grant_q[0];
    assign o_req0_read_valid = i_read_valid & grant_q[0];
    assign o_req1_read_data  = i_read_data;
    assign o_req1_read_sop   = i_read_sop & grant_q[1];
    assign o_req1_read_eop   = i_read_eop & grant_q[1];
    assign o_req1_read_valid = i_read_valid & grant_q[1];

    assign o_operation_type     = type_q;
    assign o_operation_addr     = addr_q;
    assign o_operation_byte_num = num_q;
    assign o_operation_valid    = op_valid_q;
    assign o_grant              = grant_q;
    assign o_op_err             = op_err_q;
`ifdef FLASH_ARB_TIMEOUT_EN
    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

endmodule
